// File: rtl/single_mips_pkg.sv
// Shared types and constants for the single-cycle MIPS data-memory path.
package single_mips_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } arb_state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_AUX = 1'b1;

  // Byte address to word index shift for 32-bit words.
  localparam int WORD_OFFSET = 2;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin picker: combinational pick, pointer advances past
// the winner whenever the caller strobes grant_en.
module rr_arbiter2
  import single_mips_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic [1:0] req,
  input  logic       grant_en,
  output logic       grant_valid,
  output logic       grant_idx
);

  logic rr_ptr;

  // NOTE: every output of a combinational block gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    grant_valid = |req;
    grant_idx   = PORT_CPU;
    if (req[0] && req[1]) grant_idx = rr_ptr;
    else if (req[1])      grant_idx = PORT_AUX;
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)                             rr_ptr <= PORT_CPU;
    else if (grant_en && grant_valid)    rr_ptr <= ~grant_idx;
  end

endmodule

// File: rtl/single_mips_dmem_arbiter.sv
// Two-port req/ack front end for the single-port data memory: round-robin
// grant, one registered access cycle, then a one-cycle ack with data/error.
module single_mips_dmem_arbiter
  import single_mips_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int MEM_DEPTH  = 64
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  p0_req,
  input  logic                  p0_we,
  input  logic [ADDR_WIDTH-1:0] p0_addr,
  input  logic [DATA_WIDTH-1:0] p0_wdata,
  output logic                  p0_ack,
  output logic                  p0_err,
  output logic [DATA_WIDTH-1:0] p0_rdata,
  input  logic                  p1_req,
  input  logic                  p1_we,
  input  logic [ADDR_WIDTH-1:0] p1_addr,
  input  logic [DATA_WIDTH-1:0] p1_wdata,
  output logic                  p1_ack,
  output logic                  p1_err,
  output logic [DATA_WIDTH-1:0] p1_rdata,
  output logic                  mem_wr_en,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int WIDX_W = ADDR_WIDTH - WORD_OFFSET;
  localparam logic [WIDX_W-1:0] DEPTH_WORDS = WIDX_W'(MEM_DEPTH);

  arb_state_t            state;
  logic                  owner;
  logic                  lat_we;
  logic [ADDR_WIDTH-1:0] lat_addr;
  logic [DATA_WIDTH-1:0] lat_wdata;

  logic [1:0]            arb_req;
  logic                  grant_valid;
  logic                  grant_idx;
  logic                  bad;
  logic [DATA_WIDTH-1:0] acc_rdata;

  // Only IDLE and RESP may launch; in RESP the current owner is masked out so
  // a still-high req from the port being acked is never re-granted.
  always_comb begin
    arb_req = 2'b00;
    case (state)
      IDLE:    arb_req = {p1_req, p0_req};
      RESP:    arb_req = (owner == PORT_CPU) ? {p1_req, 1'b0} : {1'b0, p0_req};
      default: arb_req = 2'b00;
    endcase
  end

  rr_arbiter2 u_rr (
    .CLK         (CLK),
    .RST         (RST),
    .req         (arb_req),
    .grant_en    (grant_valid),
    .grant_valid (grant_valid),
    .grant_idx   (grant_idx)
  );

  assign bad = (lat_addr[WORD_OFFSET-1:0] != '0) ||
               (lat_addr[ADDR_WIDTH-1:WORD_OFFSET] >= DEPTH_WORDS);

  // Write enable decodes from state so an async reset kills it immediately.
  assign mem_wr_en = (state == ACCESS) && lat_we && !bad;
  assign mem_addr  = lat_addr;
  assign mem_wdata = lat_wdata;
  assign acc_rdata = (!lat_we && !bad) ? mem_rdata : '0;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      owner     <= PORT_CPU;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      p0_ack    <= 1'b0;
      p0_err    <= 1'b0;
      p0_rdata  <= '0;
      p1_ack    <= 1'b0;
      p1_err    <= 1'b0;
      p1_rdata  <= '0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        IDLE, RESP: begin
          if (grant_valid) begin
            owner     <= grant_idx;
            lat_we    <= (grant_idx == PORT_AUX) ? p1_we    : p0_we;
            lat_addr  <= (grant_idx == PORT_AUX) ? p1_addr  : p0_addr;
            lat_wdata <= (grant_idx == PORT_AUX) ? p1_wdata : p0_wdata;
            state     <= ACCESS;
          end else begin
            state <= IDLE;
          end
        end
        ACCESS: begin
          state <= RESP;
          if (owner == PORT_CPU) begin
            p0_ack   <= 1'b1;
            p0_err   <= bad;
            p0_rdata <= acc_rdata;
          end else begin
            p1_ack   <= 1'b1;
            p1_err   <= bad;
            p1_rdata <= acc_rdata;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_single_mips_dmem_arbiter.sv
// Directed bench for single_mips_dmem_arbiter with a 64-word behavioural memory.
module tb_single_mips_dmem_arbiter;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        p0_req = 1'b0, p0_we = 1'b0;
  logic [31:0] p0_addr = '0, p0_wdata = '0;
  logic        p0_ack, p0_err;
  logic [31:0] p0_rdata;
  logic        p1_req = 1'b0, p1_we = 1'b0;
  logic [31:0] p1_addr = '0, p1_wdata = '0;
  logic        p1_ack, p1_err;
  logic [31:0] p1_rdata;
  logic        mem_wr_en;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int tests  = 0;
  int failed = 0;

  always #5 CLK = ~CLK;

  single_mips_dmem_arbiter dut (
    .CLK(CLK), .RST(RST),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_err(p0_err), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_err(p1_err), .p1_rdata(p1_rdata),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  // Memory: word i preloads to 0x1000_0000+i, except word 4 = 0x11 and word 8 = 0x22.
  logic [31:0] mem [0:63];
  logic        mem_init = 1'b0;

  function automatic logic [31:0] init_word(input int i);
    if (i == 4) return 32'h11;
    if (i == 8) return 32'h22;
    return 32'h1000_0000 + 32'(i);
  endfunction

  always @(posedge CLK) begin
    if (!mem_init) begin
      for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
      mem_init <= 1'b1;
    end else if (mem_wr_en) begin
      mem[mem_addr[7:2]] <= mem_wdata;
    end
  end

  assign mem_rdata = mem[mem_addr[7:2]];

  int          wr_total = 0;
  logic [31:0] wr_addr_seen = '0, wr_data_seen = '0;
  always @(negedge CLK) begin
    if (mem_wr_en) begin
      wr_total++;
      wr_addr_seen = mem_addr;
      wr_data_seen = mem_wdata;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One isolated transaction; lat = posedges from request sample to ack (0 = timeout).
  task automatic txn(input logic port, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, output int lat, output logic [31:0] rdata,
                     output logic err, output int wr_pulses);
    int   w0;
    logic got;
    @(negedge CLK);
    w0 = wr_total;
    if (port == 1'b0) begin
      p0_req = 1'b1; p0_we = we; p0_addr = addr; p0_wdata = wdata;
    end else begin
      p1_req = 1'b1; p1_we = we; p1_addr = addr; p1_wdata = wdata;
    end
    lat = 0; got = 1'b0; rdata = '0; err = 1'b0;
    for (int c = 1; c <= 10 && !got; c++) begin
      @(posedge CLK); #1;
      if (port == 1'b0 ? p0_ack : p1_ack) begin
        got   = 1'b1;
        lat   = c;
        rdata = port ? p1_rdata : p0_rdata;
        err   = port ? p1_err : p0_err;
      end
    end
    @(negedge CLK);
    p0_req = 1'b0;
    p1_req = 1'b0;
    wr_pulses = wr_total - w0;
  endtask

  // Both ports read at the same edge; record each port's ack cycle and data.
  task automatic contend(input string tag, input logic [31:0] a0, input logic [31:0] a1,
                         input int exp_t0, input int exp_t1,
                         input logic [31:0] exp_r0, input logic [31:0] exp_r1);
    int          t0, t1;
    logic [31:0] r0, r1;
    t0 = 0; t1 = 0; r0 = '0; r1 = '0;
    @(negedge CLK);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = a0;
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = a1;
    for (int c = 1; c <= 8; c++) begin
      @(posedge CLK); #1;
      if (p0_ack) begin t0 = c; r0 = p0_rdata; end
      if (p1_ack) begin t1 = c; r1 = p1_rdata; end
      @(negedge CLK);
      if (t0 != 0) p0_req = 1'b0;
      if (t1 != 0) p1_req = 1'b0;
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check({tag, " p0 ack cycle"}, t0, exp_t0);
    check({tag, " p1 ack cycle"}, t1, exp_t1);
    check({tag, " p0 rdata"}, r0, exp_r0);
    check({tag, " p1 rdata"}, r1, exp_r1);
  endtask

  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_wr;
  } vec_t;

  vec_t vecs [11];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          lat, wr_pulses, n0, p1_cnt, p1_lat, both;
    logic [31:0] rdata;
    logic        err, p1_started, p1_done;

    vecs[0]  = '{1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 32'h0,         1'b0, 1};
    vecs[1]  = '{1'b0, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 0};
    vecs[2]  = '{1'b1, 1'b0, 32'h10,  32'h0,        32'hDEADBEEF,  1'b0, 0};
    vecs[3]  = '{1'b1, 1'b1, 32'h13,  32'h55AA55AA, 32'h0,         1'b1, 0};
    vecs[4]  = '{1'b1, 1'b0, 32'hFC,  32'h0,        32'h1000003F,  1'b0, 0};
    vecs[5]  = '{1'b1, 1'b0, 32'h100, 32'h0,        32'h0,         1'b1, 0};
    vecs[6]  = '{1'b1, 1'b1, 32'hFC,  32'h12345678, 32'h0,         1'b0, 1};
    vecs[7]  = '{1'b0, 1'b0, 32'h02,  32'h0,        32'h0,         1'b1, 0};
    vecs[8]  = '{1'b1, 1'b0, 32'hFC,  32'h0,        32'h12345678,  1'b0, 0};
    vecs[9]  = '{1'b0, 1'b1, 32'h20,  32'hCAFEF00D, 32'h0,         1'b0, 1};
    vecs[10] = '{1'b0, 1'b0, 32'h20,  32'h0,        32'hCAFEF00D,  1'b0, 0};

    // Reset state
    repeat (3) @(negedge CLK);
    check("reset p0_ack", 32'(p0_ack), 32'h0);
    check("reset p1_ack", 32'(p1_ack), 32'h0);
    check("reset errs", {30'h0, p1_err, p0_err}, 32'h0);
    check("reset p0_rdata", p0_rdata, 32'h0);
    check("reset p1_rdata", p1_rdata, 32'h0);
    check("reset mem_wr_en", 32'(mem_wr_en), 32'h0);
    check("reset mem_addr", mem_addr, 32'h0);
    RST = 1'b0;

    // Simultaneous reads from reset: port 0 preferred, port 1 back-to-back
    contend("pair1", 32'h10, 32'h20, 2, 4, 32'h11, 32'h22);

    for (int i = 0; i < 11; i++) begin
      txn(vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata, lat, rdata, err, wr_pulses);
      check($sformatf("vec%0d latency", i), 32'(lat), 32'h2);
      check($sformatf("vec%0d err", i), 32'(err), 32'(vecs[i].exp_err));
      check($sformatf("vec%0d rdata", i), rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d wr pulses", i), 32'(wr_pulses), 32'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0) begin
        check($sformatf("vec%0d wr addr", i), wr_addr_seen, vecs[i].addr);
        check($sformatf("vec%0d wr data", i), wr_data_seen, vecs[i].wdata);
      end
    end

    // Read data holds until that port's next ack
    check("hold p0_rdata", p0_rdata, 32'hCAFEF00D);
    check("hold p1_rdata", p1_rdata, 32'h12345678);

    // Last grant went to port 0, so port 1 wins the next tie
    contend("pair2", 32'h10, 32'h20, 4, 2, 32'hDEADBEEF, 32'hCAFEF00D);

    // Reset during the ACCESS cycle of a write
    @(negedge CLK);
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 32'h30; p0_wdata = 32'hBAD0BAD0;
    @(posedge CLK); #1;
    check("midreset wr_en before", 32'(mem_wr_en), 32'h1);
    #2 RST = 1'b1;
    #1;
    check("midreset wr_en drop", 32'(mem_wr_en), 32'h0);
    @(negedge CLK);
    p0_req = 1'b0;
    @(posedge CLK); #1;
    check("midreset no ack", 32'(p0_ack), 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    txn(1'b0, 1'b0, 32'h30, 32'h0, lat, rdata, err, wr_pulses);
    check("midreset readback", rdata, 32'h1000000C);

    // Port 0 streams continuously; port 1 asks once and must not starve
    n0 = 0; p1_cnt = 0; p1_lat = 0; both = 0; p1_started = 1'b0; p1_done = 1'b0;
    @(negedge CLK);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 32'h40;
    for (int c = 0; c < 80 && n0 < 10; c++) begin
      @(posedge CLK); #1;
      if (p1_req && !p1_done) p1_cnt++;
      if (p0_ack) n0++;
      if (p0_ack && p1_ack) both++;
      if (p1_ack && !p1_done) begin
        p1_done = 1'b1;
        p1_lat  = p1_cnt;
        rdata   = p1_rdata;
      end
      @(negedge CLK);
      if (p1_done) p1_req = 1'b0;
      if (n0 == 3 && !p1_started) begin
        p1_req = 1'b1; p1_we = 1'b0; p1_addr = 32'h44;
        p1_started = 1'b1;
      end
    end
    p0_req = 1'b0;
    p1_req = 1'b0;
    check("stream p0 acks", 32'(n0), 32'd10);
    check("stream p1 served", 32'(p1_done), 32'h1);
    check("stream p1 within 4", 32'(p1_lat >= 1 && p1_lat <= 4), 32'h1);
    check("stream p1 rdata", rdata, 32'h10000011);
    check("stream p0 rdata", p0_rdata, 32'h10000010);
    check("stream no dual ack", 32'(both), 32'h0);
    repeat (4) @(negedge CLK);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
